// File: rtl/cla_pkg.sv
// cla_pkg: definitions shared by the byte-serial add arbiter.
//   state_t        - arbiter FSM states (IDLE, CALC, RESP)
//   WORDS_DEFAULT  - default operand width in bytes
//   byte_idx_width - width of the byte index register for a given WORDS
package cla_pkg;

  localparam int WORDS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // A one-byte build still needs a 1-bit index register.
  function automatic int byte_idx_width(input int words);
    int w;
    w = $clog2(words);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/cla_8bit.sv
// cla_8bit: 8-bit carry-lookahead adder, purely combinational.
// Ports:
//   a, b  in  8  operands
//   cin   in  1  carry-in
//   sum   out 8  a + b + cin, low 8 bits
//   cout  out 1  carry-out of bit 7
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g_s;
  logic [7:0] p_s;
  logic [8:0] c_s;

  // Generate/propagate terms; each carry is formed from its own lookahead term set.
  always_comb begin : carry_p
    logic acc;
    acc = 1'b0;
    g_s = a & b;
    p_s = a ^ b;
    c_s = 9'd0;
    c_s[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc = cin;
      for (int j = 0; j <= i; j++) begin
        acc = g_s[j] | (p_s[j] & acc);
      end
      c_s[i+1] = acc;
    end
    sum  = p_s ^ c_s[7:0];
    cout = c_s[8];
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// cla_add_arbiter: two requesters share one cla_8bit. A granted request is
// added byte-serially, LSB first, with the carry chained through carry_r,
// and the result is returned on a valid/ready port tagged with the id.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid / reqN_ready    request handshake (ready combinational, IDLE only)
//   reqN_a, reqN_b, reqN_cin   operands (8*WORDS bits) and carry-in
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_sum, rsp_cout  owning requester, sum, final carry (registered)
module cla_add_arbiter
  import cla_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [8*WORDS-1:0] req0_a,
  input  logic [8*WORDS-1:0] req0_b,
  input  logic               req0_cin,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [8*WORDS-1:0] req1_a,
  input  logic [8*WORDS-1:0] req1_b,
  input  logic               req1_cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [8*WORDS-1:0] rsp_sum,
  output logic               rsp_cout
);

  localparam int KW = byte_idx_width(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t             state_r;
  logic [8*WORDS-1:0] a_r;
  logic [8*WORDS-1:0] b_r;
  logic [8*WORDS-1:0] sum_r;
  logic [KW-1:0]      k_r;
  logic               carry_r;
  logic               id_r;
  logic               last_grant_r;
  logic               rsp_valid_r;
  logic               rsp_cout_r;

  logic               grant_s;
  logic               ready0_s;
  logic               ready1_s;
  logic               accept_s;
  logic [KW+2:0]      byte_off_s;
  logic [7:0]         add_a_s;
  logic [7:0]         add_b_s;
  logic [7:0]         add_sum_s;
  logic               add_cout_s;

  // Round-robin grant: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant_s  = 1'b0;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (state_r == IDLE) begin
      ready0_s = req0_valid & ~grant_s;
      ready1_s = req1_valid & grant_s;
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
  end

  assign accept_s = (req0_valid & ready0_s) | (req1_valid & ready1_s);

  // Select the current byte of each latched operand for the shared adder.
  always_comb begin
    byte_off_s = {k_r, 3'b000};
    add_a_s    = a_r[byte_off_s +: 8];
    add_b_s    = b_r[byte_off_s +: 8];
  end

  cla_8bit u_cla (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (carry_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Arbiter FSM with operand, sum, carry and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      a_r          <= '0;
      b_r          <= '0;
      sum_r        <= '0;
      k_r          <= '0;
      carry_r      <= 1'b0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_cout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r          <= grant_s ? req1_a : req0_a;
            b_r          <= grant_s ? req1_b : req0_b;
            carry_r      <= grant_s ? req1_cin : req0_cin;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
            k_r          <= '0;
            state_r      <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          sum_r[byte_off_s +: 8] <= add_sum_s;
          carry_r                <= add_cout_s;
          if (k_r == K_LAST) begin
            k_r         <= '0;
            rsp_cout_r  <= add_cout_s;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            k_r     <= k_r + {{(KW-1){1'b0}}, 1'b1};
            state_r <= CALC;
          end
        end
        RESP: begin
          // Requests are only accepted from IDLE, so a handshake here
          // always leaves one bubble cycle before the next accept.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = id_r;
  assign rsp_sum    = sum_r;
  assign rsp_cout   = rsp_cout_r;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter: a 4-byte instance and a 1-byte
// instance, expected results held in a scoreboard queue.
module tb_cla_add_arbiter;

  localparam int W4 = 4;

  typedef struct packed {
    logic        id;
    logic [31:0] sum;
    logic        cout;
  } sb_t;

  logic clk;
  logic rst_n;

  // 4-byte instance
  logic        v0, v1, c0, c1, rr;
  logic [31:0] a0, b0, a1, b1;
  logic        r0, r1, rv, rid, rcout;
  logic [31:0] rsum;

  // 1-byte instance
  logic       q_v0, q_v1, q_c0, q_c1, q_rr;
  logic [7:0] q_a0, q_b0, q_a1, q_b1;
  logic       q_r0, q_r1, q_rv, q_rid, q_rcout;
  logic [7:0] q_rsum;

  int  checks = 0;
  int  errors = 0;
  sb_t sb[$];

  cla_add_arbiter #(.WORDS(W4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_sum(rsum), .rsp_cout(rcout)
  );

  cla_add_arbiter #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q_v0), .req0_ready(q_r0), .req0_a(q_a0), .req0_b(q_b0), .req0_cin(q_c0),
    .req1_valid(q_v1), .req1_ready(q_r1), .req1_a(q_a1), .req1_b(q_b1), .req1_cin(q_c1),
    .rsp_valid(q_rv), .rsp_ready(q_rr), .rsp_id(q_rid), .rsp_sum(q_rsum), .rsp_cout(q_rcout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the request inputs already driven.
  task automatic serve(input logic exp_id, input int stall, input bit drop);
    logic [32:0] full;
    sb_t e;
    int lat;
    #1;
    check("ready0_grant", 64'(r0), 64'(exp_id == 1'b0));
    check("ready1_grant", 64'(r1), 64'(exp_id == 1'b1));
    if (exp_id == 1'b0) full = {1'b0, a0} + {1'b0, b0} + {32'd0, c0};
    else                full = {1'b0, a1} + {1'b0, b1} + {32'd0, c1};
    e.id = exp_id; e.sum = full[31:0]; e.cout = full[32];
    sb.push_back(e);
    rr = (stall == 0);
    @(negedge clk);
    lat = 1;
    if (drop) begin
      if (exp_id) v1 = 1'b0;
      else        v0 = 1'b0;
    end
    #1;
    while (!rv && lat < 40) begin
      check("busy_ready", 64'({r1, r0}), 64'(2'b00));
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(W4 + 1));
    if (!rv) begin
      sb.delete();
      return;
    end
    for (int i = 0; i < stall; i++) begin
      check("bp_valid", 64'(rv), 64'(1'b1));
      check("bp_sum", 64'(rsum), 64'(sb[0].sum));
      check("bp_id", 64'(rid), 64'(sb[0].id));
      check("bp_cout", 64'(rcout), 64'(sb[0].cout));
      check("bp_ready", 64'({r1, r0}), 64'(2'b00));
      @(negedge clk);
    end
    rr = 1'b1;
    #1;
    check("rsp_valid", 64'(rv), 64'(1'b1));
    check("sb_nonempty", 64'(sb.size()), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_id", 64'(rid), 64'(e.id));
      check("rsp_sum", 64'(rsum), 64'(e.sum));
      check("rsp_cout", 64'(rcout), 64'(e.cout));
    end
    @(negedge clk);
    check("rsp_drop", 64'(rv), 64'(1'b0));
  endtask

  // One-byte instance: single request, drop after accept, check result.
  task automatic serve1(input logic id, input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] full;
    sb_t e;
    int lat;
    @(negedge clk);
    if (id) begin q_v1 = 1'b1; q_a1 = a; q_b1 = b; q_c1 = cin; end
    else    begin q_v0 = 1'b1; q_a0 = a; q_b0 = b; q_c0 = cin; end
    #1;
    check("w1_ready", 64'({q_r1, q_r0}), id ? 64'(2'b10) : 64'(2'b01));
    full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    e.id = id; e.sum = {24'd0, full[7:0]}; e.cout = full[8];
    sb.push_back(e);
    @(negedge clk);
    q_v0 = 1'b0; q_v1 = 1'b0;
    lat = 1;
    #1;
    while (!q_rv && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w1_latency", 64'(lat), 64'(2));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("w1_id", 64'(q_rid), 64'(e.id));
      check("w1_sum", 64'({24'd0, q_rsum}), 64'(e.sum));
      check("w1_cout", 64'(q_rcout), 64'(e.cout));
    end
    @(negedge clk);
    check("w1_drop", 64'(q_rv), 64'(1'b0));
  endtask

  initial begin
    logic exp_order [4];
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    rst_n = 1'b0; rr = 1'b1; q_rr = 1'b1;
    v0 = 1'b0; v1 = 1'b0; c0 = 1'b0; c1 = 1'b0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
    q_v0 = 1'b0; q_v1 = 1'b0; q_c0 = 1'b0; q_c1 = 1'b0;
    q_a0 = 8'd0; q_b0 = 8'd0; q_a1 = 8'd0; q_b1 = 8'd0;
    #1;
    // Reset state
    check("rst_ready", 64'({r1, r0}), 64'(2'b00));
    check("rst_valid", 64'(rv), 64'(1'b0));
    check("rst_id", 64'(rid), 64'(1'b0));
    check("rst_sum", 64'(rsum), 64'(32'd0));
    check("rst_cout", 64'(rcout), 64'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single request with a byte carry
    v0 = 1'b1; a0 = 32'h0000_00FF; b0 = 32'h0000_0001; c0 = 1'b0;
    serve(1'b0, 0, 1'b1);
    // 2: full carry chain
    v0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0000; c0 = 1'b1;
    serve(1'b0, 0, 1'b1);
    // 4: backpressure; requester 0 stays valid and must see ready low
    v0 = 1'b1; a0 = $urandom; b0 = $urandom; c0 = 1'b1;
    v1 = 1'b1; a1 = $urandom; b1 = $urandom; c1 = 1'b1;
    serve(1'b1, 10, 1'b1);
    // 3: both requesters valid back to back
    v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(exp_order[i], 0, 1'b0);
      if (exp_order[i]) begin a1 = $urandom; b1 = $urandom; c1 = ~c1; end
      else              begin a0 = $urandom; b0 = $urandom; c0 = ~c0; end
    end
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);

    // 5: reset two cycles after the accept
    v0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h9ABC_DEF0; c0 = 1'b0;
    #1;
    check("r5_ready0", 64'(r0), 64'(1'b1));
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("r5_valid", 64'(rv), 64'(1'b0));
    check("r5_ready", 64'({r1, r0}), 64'(2'b00));
    check("r5_id", 64'(rid), 64'(1'b0));
    check("r5_sum", 64'(rsum), 64'(32'd0));
    check("r5_cout", 64'(rcout), 64'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("r5_no_rsp", 64'(rv), 64'(1'b0));
    end
    v0 = 1'b1; v1 = 1'b1; a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    serve(1'b0, 0, 1'b1);
    v1 = 1'b0;

    // 6: one-byte build
    serve1(1'b0, 8'h80, 8'h80, 1'b0);
    serve1(1'b1, 8'h7F, 8'h01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
